id_decode_buffer: RTL and testbench

Next-generation ID-stage front end. It buffers fetched instructions in a parametrised FIFO and decodes the head entry: fields, control bundle, immediate, CSR access and illegal-instruction detection. It presents the decoded result in a registered output slot under a valid/ready handshake. It sits between IF and the ID/EX register and absorbs EX stalls and branch flushes.

---
 rtl/id_decode_buffer_pkg.sv | 83 ++++++++
 rtl/id_decode_buffer_inst_decode.sv | 151 +++++++++++++++
 rtl/id_decode_buffer.sv | 130 +++++++++++++
 tb/tb_id_decode_buffer.sv | 417 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/id_decode_buffer_pkg.sv
// Shared constants and types for the ID-stage decode buffer.
// Opcodes, funct codes, write sizes, immediate formats, decode bundle.
package id_decode_buffer_pkg;

  localparam logic [6:0] OPC_LUI      = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
  localparam logic [6:0] OPC_JAL      = 7'b1101111;
  localparam logic [6:0] OPC_JALR     = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
  localparam logic [6:0] OPC_LOAD     = 7'b0000011;
  localparam logic [6:0] OPC_STORE    = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_OP       = 7'b0110011;
  localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;
  localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;

  localparam logic [2:0] F3_LB  = 3'd0;
  localparam logic [2:0] F3_LH  = 3'd1;
  localparam logic [2:0] F3_LW  = 3'd2;
  localparam logic [2:0] F3_LBU = 3'd4;
  localparam logic [2:0] F3_LHU = 3'd5;

  localparam logic [2:0] F3_SB = 3'd0;
  localparam logic [2:0] F3_SH = 3'd1;
  localparam logic [2:0] F3_SW = 3'd2;

  localparam logic [2:0] F3_BEQ  = 3'd0;
  localparam logic [2:0] F3_BNE  = 3'd1;
  localparam logic [2:0] F3_BLT  = 3'd4;
  localparam logic [2:0] F3_BGE  = 3'd5;
  localparam logic [2:0] F3_BLTU = 3'd6;
  localparam logic [2:0] F3_BGEU = 3'd7;

  localparam logic [2:0] F3_SLL = 3'd1;
  localparam logic [2:0] F3_SRX = 3'd5;
  localparam logic [2:0] F3_ADD = 3'd0;

  localparam logic [6:0] F7_BASE = 7'h00;
  localparam logic [6:0] F7_ALT  = 7'h20;

  localparam logic [1:0] WRITE_IDLE = 2'd0;
  localparam logic [1:0] WRITE_BYTE = 2'd1;
  localparam logic [1:0] WRITE_HALF = 2'd2;
  localparam logic [1:0] WRITE_WORD = 2'd3;

  localparam logic [2:0] F3_PRIV    = 3'd0;
  localparam logic [2:0] F3_CSRRW   = 3'd1;
  localparam logic [2:0] F3_CSRRS   = 3'd2;
  localparam logic [2:0] F3_CSRRC   = 3'd3;
  localparam logic [2:0] F3_CSR_RSV = 3'd4;
  localparam logic [2:0] F3_CSRRWI  = 3'd5;
  localparam logic [2:0] F3_CSRRSI  = 3'd6;
  localparam logic [2:0] F3_CSRRCI  = 3'd7;

  typedef enum logic [2:0] {
    IMM_NONE,
    IMM_I,
    IMM_S,
    IMM_B,
    IMM_U,
    IMM_J
  } imm_fmt_e;

  typedef struct packed {
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic        branch;
    logic        jump;
    logic        mem_read;
    logic        mem_to_reg;
    logic        alu_src;
    logic        reg_write;
    logic [1:0]  mem_write;
    logic        csr_we;
    logic        csr_re;
    logic [11:0] csr_addr;
    logic        illegal;
  } dec_t;

endpackage

// File: rtl/id_decode_buffer_inst_decode.sv
// Combinational RV32I + Zicsr decode of one instruction word.
// Produces fields, control bundle, immediate, CSR access, illegal flag.
module id_inst_decode
  import id_decode_buffer_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter bit CSR_EN = 1'b1
) (
  input  logic [31:0]     i_instr,
  output dec_t            o_dec,
  output logic [XLEN-1:0] o_imm
);

  logic [6:0] w_op;
  logic [6:0] w_f7;
  logic [2:0] w_f3;
  logic [4:0] w_rd;
  logic [4:0] w_rs1;
  logic [5:0] w_ctl;
  logic [1:0] w_mw;
  logic       w_bad;
  logic       w_csr;
  logic       w_csr_ok;
  logic       w_rw_op;
  logic       w_sc_op;
  imm_fmt_e   w_fmt;
  logic [31:0] w_imm;

  assign w_op  = i_instr[6:0];
  assign w_rd  = i_instr[11:7];
  assign w_f3  = i_instr[14:12];
  assign w_rs1 = i_instr[19:15];
  assign w_f7  = i_instr[31:25];

  // w_ctl = {branch, jump, mem_read, mem_to_reg, alu_src, reg_write}
  always_comb begin
    w_ctl = '0;
    w_fmt = IMM_NONE;
    w_mw  = WRITE_IDLE;
    w_bad = 1'b0;
    w_csr = 1'b0;
    unique case (1'b1)
      (w_op == OPC_LUI),
      (w_op == OPC_AUIPC): begin
        w_ctl = 6'b000011;
        w_fmt = IMM_U;
      end
      (w_op == OPC_JAL): begin
        w_ctl = 6'b010011;
        w_fmt = IMM_J;
      end
      (w_op == OPC_JALR): begin
        w_ctl = 6'b010011;
        w_fmt = IMM_I;
        w_bad = (w_f3 != F3_ADD);
      end
      (w_op == OPC_BRANCH): begin
        w_ctl = 6'b100000;
        w_fmt = IMM_B;
        w_bad = !(w_f3 inside {F3_BEQ, F3_BNE, F3_BLT,
                               F3_BGE, F3_BLTU, F3_BGEU});
      end
      (w_op == OPC_LOAD): begin
        w_ctl = 6'b001111;
        w_fmt = IMM_I;
        w_bad = !(w_f3 inside {F3_LB, F3_LH, F3_LW,
                               F3_LBU, F3_LHU});
      end
      (w_op == OPC_STORE): begin
        w_ctl = 6'b000010;
        w_fmt = IMM_S;
        case (w_f3)
          F3_SB:   w_mw = WRITE_BYTE;
          F3_SH:   w_mw = WRITE_HALF;
          F3_SW:   w_mw = WRITE_WORD;
          default: w_bad = 1'b1;
        endcase
      end
      (w_op == OPC_OP_IMM): begin
        w_ctl = 6'b000011;
        w_fmt = IMM_I;
        w_bad = (w_f3 == F3_SLL && w_f7 != F7_BASE) ||
                (w_f3 == F3_SRX &&
                 !(w_f7 inside {F7_BASE, F7_ALT}));
      end
      (w_op == OPC_OP): begin
        w_ctl = 6'b000001;
        w_bad = !(w_f7 == F7_BASE ||
                  (w_f7 == F7_ALT &&
                   w_f3 inside {F3_ADD, F3_SRX}));
      end
      (w_op == OPC_SYSTEM): begin
        if (w_f3 != F3_PRIV) begin
          w_ctl = 6'b000001;
          w_csr = 1'b1;
          w_bad = !CSR_EN || (w_f3 == F3_CSR_RSV);
        end
      end
      (w_op == OPC_MISC_MEM): begin
        w_ctl = 6'b000000;
      end
      default: w_bad = 1'b1;
    endcase
    if (i_instr[1:0] != 2'b11) w_bad = 1'b1;
  end

  assign w_csr_ok = w_csr && !w_bad;
  assign w_rw_op  = w_f3 inside {F3_CSRRW, F3_CSRRWI};
  assign w_sc_op  = w_f3 inside {F3_CSRRS, F3_CSRRC,
                                 F3_CSRRSI, F3_CSRRCI};

  always_comb begin
    unique case (w_fmt)
      IMM_I: w_imm = {{20{i_instr[31]}}, i_instr[31:20]};
      IMM_S: w_imm = {{20{i_instr[31]}}, i_instr[31:25],
                      i_instr[11:7]};
      IMM_B: w_imm = {{19{i_instr[31]}}, i_instr[31],
                      i_instr[7], i_instr[30:25],
                      i_instr[11:8], 1'b0};
      IMM_U: w_imm = {i_instr[31:12], 12'h000};
      IMM_J: w_imm = {{11{i_instr[31]}}, i_instr[31],
                      i_instr[19:12], i_instr[20],
                      i_instr[30:21], 1'b0};
      default: w_imm = '0;
    endcase
  end

  assign o_imm = XLEN'($signed(w_imm));

  // An illegal word still flows, but with every side effect suppressed.
  always_comb begin
    o_dec            = '0;
    o_dec.rs1        = w_rs1;
    o_dec.rs2        = i_instr[24:20];
    o_dec.rd         = w_rd;
    o_dec.funct3     = w_f3;
    o_dec.funct7     = w_f7;
    o_dec.branch     = w_ctl[5] && !w_bad;
    o_dec.jump       = w_ctl[4] && !w_bad;
    o_dec.mem_read   = w_ctl[3] && !w_bad;
    o_dec.mem_to_reg = w_ctl[2];
    o_dec.alu_src    = w_ctl[1];
    o_dec.reg_write  = w_ctl[0] && !w_bad && (w_rd != 5'd0);
    o_dec.mem_write  = w_bad ? WRITE_IDLE : w_mw;
    o_dec.csr_we     = w_csr_ok && (w_rw_op || w_rs1 != 5'd0);
    o_dec.csr_re     = w_csr_ok && (w_sc_op || w_rd != 5'd0);
    o_dec.csr_addr   = w_csr_ok ? i_instr[31:20] : 12'h000;
    o_dec.illegal    = w_bad;
  end

endmodule

// File: rtl/id_decode_buffer.sv
// ID-stage front end: instruction FIFO feeding a registered
// decode slot with valid/ready handshake and flush.
module id_decode_buffer
  import id_decode_buffer_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int XLEN   = 32,
  parameter bit CSR_EN = 1'b1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     if_valid,
  output logic                     if_ready,
  input  logic [31:0]              if_instr,
  input  logic [XLEN-1:0]          if_pc,
  input  logic                     ex_ready,
  output logic                     id_valid,
  output logic [XLEN-1:0]          id_pc,
  output logic [4:0]               rs1,
  output logic [4:0]               rs2,
  output logic [4:0]               rd,
  output logic [2:0]               funct3,
  output logic [6:0]               funct7,
  output logic [XLEN-1:0]          imm,
  output logic                     branch,
  output logic                     jump,
  output logic                     mem_read,
  output logic                     mem_to_reg,
  output logic                     alu_src,
  output logic                     reg_write,
  output logic [1:0]               mem_write,
  output logic                     csr_we,
  output logic                     csr_re,
  output logic [11:0]              csr_addr,
  output logic                     illegal,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] L_DEPTH = (AW+1)'(DEPTH);

  logic [31:0]     r_instr [DEPTH];
  logic [XLEN-1:0] r_pcs   [DEPTH];
  logic [AW-1:0]   r_wptr;
  logic [AW-1:0]   r_rptr;
  logic [AW:0]     r_count;
  logic            r_valid;
  dec_t            r_dec;
  logic [XLEN-1:0] r_imm;
  logic [XLEN-1:0] r_id_pc;

  dec_t            w_dec;
  logic [XLEN-1:0] w_imm;
  logic            w_push;
  logic            w_pop;

  id_inst_decode #(
    .XLEN   (XLEN),
    .CSR_EN (CSR_EN)
  ) u_dec (
    .i_instr (r_instr[r_rptr]),
    .o_dec   (w_dec),
    .o_imm   (w_imm)
  );

  // Readiness depends on registered occupancy only, never on ex_ready.
  assign if_ready = (r_count < L_DEPTH);
  assign w_push   = if_valid && if_ready;
  assign w_pop    = (r_count != '0) && (!r_valid || ex_ready);

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_instr[r_wptr] <= if_instr;
      r_pcs[r_wptr]   <= if_pc;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_valid <= 1'b0;
      r_dec   <= '0;
      r_imm   <= '0;
      r_id_pc <= '0;
    end else if (flush) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_valid <= 1'b0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop) begin
        r_rptr  <= r_rptr + 1'b1;
        r_valid <= 1'b1;
        r_dec   <= w_dec;
        r_imm   <= w_imm;
        r_id_pc <= r_pcs[r_rptr];
      end else if (ex_ready) begin
        r_valid <= 1'b0;
      end
      if (w_push && !w_pop) r_count <= r_count + 1'b1;
      else if (!w_push && w_pop) r_count <= r_count - 1'b1;
    end
  end

  assign id_valid   = r_valid;
  assign id_pc      = r_id_pc;
  assign imm        = r_imm;
  assign rs1        = r_dec.rs1;
  assign rs2        = r_dec.rs2;
  assign rd         = r_dec.rd;
  assign funct3     = r_dec.funct3;
  assign funct7     = r_dec.funct7;
  assign branch     = r_dec.branch;
  assign jump       = r_dec.jump;
  assign mem_read   = r_dec.mem_read;
  assign mem_to_reg = r_dec.mem_to_reg;
  assign alu_src    = r_dec.alu_src;
  assign reg_write  = r_dec.reg_write;
  assign mem_write  = r_dec.mem_write;
  assign csr_we     = r_dec.csr_we;
  assign csr_re     = r_dec.csr_re;
  assign csr_addr   = r_dec.csr_addr;
  assign illegal    = r_dec.illegal;
  assign count      = r_count;

endmodule

// File: tb/tb_id_decode_buffer.sv
// Randomized and directed bench for id_decode_buffer against a
// queue-based FIFO model and an arithmetic decode reference.
module tb_id_decode_buffer;

  localparam int DEPTH = 4;

  typedef struct packed {
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] imm;
    logic        br;
    logic        jmp;
    logic        mr;
    logic        m2r;
    logic        as;
    logic        rw;
    logic [1:0]  mw;
    logic        cwe;
    logic        cre;
    logic [11:0] caddr;
    logic        ill;
  } ov_t;

  logic        clk, rst_n, flush, if_valid, if_ready, ex_ready;
  logic [31:0] if_instr, if_pc, id_pc, imm;
  logic        id_valid;
  logic [4:0]  rs1, rs2, rd;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic        branch, jump, mem_read, mem_to_reg, alu_src, reg_write;
  logic [1:0]  mem_write;
  logic        csr_we, csr_re, illegal;
  logic [11:0] csr_addr;
  logic [2:0]  count;

  int n_tests = 0;
  int n_fail  = 0;

  logic [63:0] mq[$];
  bit          sv;
  logic [63:0] sd;

  id_decode_buffer #(.DEPTH(DEPTH), .XLEN(32), .CSR_EN(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .if_valid(if_valid), .if_ready(if_ready),
    .if_instr(if_instr), .if_pc(if_pc), .ex_ready(ex_ready),
    .id_valid(id_valid), .id_pc(id_pc),
    .rs1(rs1), .rs2(rs2), .rd(rd),
    .funct3(funct3), .funct7(funct7), .imm(imm),
    .branch(branch), .jump(jump), .mem_read(mem_read),
    .mem_to_reg(mem_to_reg), .alu_src(alu_src),
    .reg_write(reg_write), .mem_write(mem_write),
    .csr_we(csr_we), .csr_re(csr_re), .csr_addr(csr_addr),
    .illegal(illegal), .count(count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] sx(input longint v, input int n);
    longint m;
    m = longint'(1) << (n - 1);
    v = v & ((m << 1) - 1);
    return 32'((v ^ m) - m);
  endfunction

  function automatic ov_t ref_dec(input logic [31:0] i);
    ov_t o;
    logic [6:0] op;
    logic [2:0] f3;
    logic [6:0] f7;
    logic [5:0] c;
    bit bad, csr;
    op = i[6:0]; f3 = i[14:12]; f7 = i[31:25];
    c = '0; bad = 0; csr = 0;
    o = '0;
    o.rs1 = i[19:15]; o.rs2 = i[24:20]; o.rd = i[11:7];
    o.f3 = f3; o.f7 = f7;
    case (op)
      7'h37, 7'h17: begin
        c = 6'b000011; o.imm = i[31:12] * 32'd4096;
      end
      7'h6F: begin
        c = 6'b010011;
        o.imm = sx(i[31] * (1 << 20) + i[19:12] * (1 << 12)
                   + i[20] * (1 << 11) + i[30:21] * 2, 21);
      end
      7'h67: begin
        c = 6'b010011; o.imm = sx(i[31:20], 12); bad = f3 != 0;
      end
      7'h63: begin
        c = 6'b100000;
        o.imm = sx(i[31] * 4096 + i[7] * 2048
                   + i[30:25] * 32 + i[11:8] * 2, 13);
        bad = (f3 == 2 || f3 == 3);
      end
      7'h03: begin
        c = 6'b001111; o.imm = sx(i[31:20], 12);
        bad = (f3 == 3 || f3 >= 6);
      end
      7'h23: begin
        c = 6'b000010; o.imm = sx(i[31:25] * 32 + i[11:7], 12);
        bad = f3 > 2;
        if (!bad) o.mw = 2'(f3 + 1);
      end
      7'h13: begin
        c = 6'b000011; o.imm = sx(i[31:20], 12);
        bad = (f3 == 1 && f7 != 0) ||
              (f3 == 5 && f7 != 0 && f7 != 7'h20);
      end
      7'h33: begin
        c = 6'b000001;
        bad = !(f7 == 0 || (f7 == 7'h20 && (f3 == 0 || f3 == 5)));
      end
      7'h73: begin
        if (f3 != 0) begin
          c = 6'b000001; csr = 1; bad = (f3 == 4);
        end
      end
      7'h0F: c = 6'b000000;
      default: bad = 1;
    endcase
    if (csr && !bad) begin
      o.caddr = i[31:20];
      if (f3 == 1 || f3 == 5) begin
        o.cwe = 1; o.cre = (o.rd != 0);
      end else begin
        o.cre = 1; o.cwe = (o.rs1 != 0);
      end
    end
    {o.br, o.jmp, o.mr, o.m2r, o.as, o.rw} = c;
    if (o.rd == 0) o.rw = 0;
    if (bad) begin
      o.br = 0; o.jmp = 0; o.mr = 0; o.rw = 0;
      o.mw = 0; o.cwe = 0; o.cre = 0;
    end
    o.ill = bad;
    return o;
  endfunction

  function automatic ov_t dut_vec();
    ov_t o;
    o = '{rs1, rs2, rd, funct3, funct7, imm, branch, jump,
          mem_read, mem_to_reg, alu_src, reg_write, mem_write,
          csr_we, csr_re, csr_addr, illegal};
    return o;
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [6:0] ops [12];
    logic [31:0] w;
    int s;
    ops = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03,
            7'h23, 7'h13, 7'h33, 7'h73, 7'h0F, 7'h7F};
    w = $urandom();
    s = $urandom_range(0, 3);
    if ($urandom_range(0, 9) != 0) w[6:0] = ops[$urandom_range(0, 11)];
    if (s == 0) w[31:25] = 7'h00;
    else if (s == 1) w[31:25] = 7'h20;
    return w;
  endfunction

  task automatic drive_cycle(input bit v, input logic [31:0] ins,
                             input logic [31:0] p, input bit er,
                             input bit fl);
    bit pu, po;
    if_valid = v; if_instr = ins; if_pc = p;
    ex_ready = er; flush = fl;
    pu = v && (mq.size() < DEPTH);
    po = (mq.size() != 0) && (!sv || er);
    if (fl) begin
      mq.delete(); sv = 0;
    end else begin
      if (po) begin
        sd = mq.pop_front(); sv = 1;
      end else if (er) begin
        sv = 0;
      end
      if (pu) mq.push_back({ins, p});
    end
    @(posedge clk); #1;
    if_valid = 1'b0; flush = 1'b0;
  endtask

  task automatic drain();
    repeat (DEPTH + 2) drive_cycle(0, 0, 0, 1, 0);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; flush = 1'b0; if_valid = 1'b0;
    ex_ready = 1'b0; if_instr = '0; if_pc = '0;
    repeat (2) @(posedge clk);
    #1;
    mq.delete(); sv = 0;
    n_tests++;
    if (dut_vec() !== '0 || id_valid !== 1'b0 ||
        count !== 3'd0 || id_pc !== 32'h0) begin
      n_fail++;
      $display("FAIL reset: valid=%b count=%0d pc=%h vec=%h, need 0",
               id_valid, count, id_pc, dut_vec());
    end
    n_tests++;
    if (if_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_ready: got %b need 1", if_ready);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_store();
    drain();
    drive_cycle(1, 32'h00512423, 32'h100, 1, 0);
    n_tests++;
    if (id_valid !== 1'b0 || count !== 3'd1) begin
      n_fail++;
      $display("FAIL store_latency: valid=%b count=%0d need 0/1",
               id_valid, count);
    end
    drive_cycle(0, 0, 0, 1, 0);
    n_tests++;
    if (id_valid !== 1'b1 || id_pc !== 32'h100 ||
        mem_write !== 2'd3 || imm !== 32'd8 ||
        reg_write !== 1'b0 || illegal !== 1'b0 ||
        rs1 !== 5'd2 || rs2 !== 5'd5) begin
      n_fail++;
      $display("FAIL store_sw: v=%b pc=%h mw=%0d imm=%h rw=%b ill=%b, need 1 100 3 8 0 0",
               id_valid, id_pc, mem_write, imm, reg_write, illegal);
    end
    n_tests++;
    if (dut_vec() !== ref_dec(32'h00512423)) begin
      n_fail++;
      $display("FAIL store_model: got %h need %h",
               dut_vec(), ref_dec(32'h00512423));
    end
    drive_cycle(0, 0, 0, 1, 0);
    n_tests++;
    if (id_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL store_drain: valid=%b need 0", id_valid);
    end
  endtask

  task automatic test_backpressure();
    drain();
    for (int k = 0; k < 5; k++)
      drive_cycle(1, 32'h00000093 | (32'(k) << 20),
                  32'h200 + 32'(4 * k), 0, 0);
    n_tests++;
    if (count !== 3'd4 || if_ready !== 1'b0 ||
        id_valid !== 1'b1 || id_pc !== 32'h200) begin
      n_fail++;
      $display("FAIL bp_full: count=%0d rdy=%b v=%b pc=%h need 4 0 1 200",
               count, if_ready, id_valid, id_pc);
    end
    drive_cycle(1, 32'h00900093, 32'h2F0, 0, 0);
    n_tests++;
    if (count !== 3'd4 || id_pc !== 32'h200) begin
      n_fail++;
      $display("FAIL bp_push_full: count=%0d pc=%h need 4 200",
               count, id_pc);
    end
    for (int k = 1; k < 5; k++) begin
      drive_cycle(0, 0, 0, 1, 0);
      n_tests++;
      if (id_valid !== 1'b1 || id_pc !== 32'h200 + 32'(4 * k) ||
          imm !== 32'(k) || int'(count) !== 4 - k) begin
        n_fail++;
        $display("FAIL bp_drain%0d: v=%b pc=%h imm=%h count=%0d",
                 k, id_valid, id_pc, imm, count);
      end
    end
    drive_cycle(0, 0, 0, 1, 0);
    n_tests++;
    if (id_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_empty: valid=%b need 0", id_valid);
    end
  endtask

  task automatic test_csr();
    drain();
    drive_cycle(1, 32'h30002073, 32'h500, 1, 0);
    drive_cycle(0, 0, 0, 1, 0);
    n_tests++;
    if (id_valid !== 1'b1 || csr_re !== 1'b1 || csr_we !== 1'b0 ||
        csr_addr !== 12'h300 || reg_write !== 1'b0 ||
        illegal !== 1'b0) begin
      n_fail++;
      $display("FAIL csrrs: v=%b re=%b we=%b addr=%h rw=%b, need 1 1 0 300 0",
               id_valid, csr_re, csr_we, csr_addr, reg_write);
    end
  endtask

  task automatic test_illegal();
    logic [31:0] bad [2];
    bad = '{32'h0000707F, 32'h00003003};
    drain();
    drive_cycle(1, bad[0], 32'h600, 1, 0);
    drive_cycle(1, bad[1], 32'h604, 1, 0);
    for (int k = 0; k < 2; k++) begin
      n_tests++;
      if (id_valid !== 1'b1 || illegal !== 1'b1 ||
          id_pc !== 32'h600 + 32'(4 * k) ||
          {reg_write, mem_write, mem_read, csr_we, csr_re,
           branch, jump} !== 8'h00) begin
        n_fail++;
        $display("FAIL illegal%0d: v=%b ill=%b pc=%h en=%b",
                 k, id_valid, illegal, id_pc,
                 {reg_write, mem_write, mem_read, csr_we, csr_re,
                  branch, jump});
      end
      drive_cycle(0, 0, 0, 1, 0);
    end
  endtask

  task automatic test_flush();
    drain();
    for (int k = 0; k < 4; k++)
      drive_cycle(1, 32'h00100093, 32'h300 + 32'(4 * k), 0, 0);
    n_tests++;
    if (count !== 3'd3 || id_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL flush_fill: count=%0d v=%b need 3 1",
               count, id_valid);
    end
    drive_cycle(1, 32'h00200093, 32'h400, 0, 1);
    n_tests++;
    if (count !== 3'd0 || id_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL flush: count=%0d v=%b need 0 0",
               count, id_valid);
    end
    for (int k = 0; k < 3; k++) begin
      drive_cycle(0, 0, 0, 1, 0);
      n_tests++;
      if (count !== 3'd0 || id_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL flush_after%0d: count=%0d v=%b need 0 0",
                 k, count, id_valid);
      end
    end
  endtask

  task automatic test_addi();
    drain();
    drive_cycle(1, 32'h00100013, 32'h700, 1, 0);
    drive_cycle(0, 0, 0, 1, 0);
    n_tests++;
    if (id_valid !== 1'b1 || reg_write !== 1'b0 ||
        alu_src !== 1'b1 || imm !== 32'd1 || illegal !== 1'b0) begin
      n_fail++;
      $display("FAIL addi_x0: v=%b rw=%b as=%b imm=%h, need 1 0 1 1",
               id_valid, reg_write, alu_src, imm);
    end
  endtask

  task automatic test_reset_mid();
    drain();
    for (int k = 0; k < 3; k++)
      drive_cycle(1, 32'hFFF00093, 32'h800 + 32'(4 * k), 0, 0);
    rst_n = 1'b0;
    @(posedge clk); #1;
    mq.delete(); sv = 0;
    n_tests++;
    if (dut_vec() !== '0 || id_valid !== 1'b0 ||
        count !== 3'd0 || id_pc !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_mid: v=%b count=%0d pc=%h vec=%h, need 0",
               id_valid, count, id_pc, dut_vec());
    end
    rst_n = 1'b1;
  endtask

  task automatic test_random();
    for (int c = 0; c < 600; c++) begin
      bit v, er, fl;
      v  = ($urandom_range(0, 3) != 0);
      er = ($urandom_range(0, 3) != 0);
      fl = ($urandom_range(0, 40) == 0);
      drive_cycle(v, rand_instr(), $urandom(), er, fl);
      n_tests++;
      if (int'(count) !== mq.size() || id_valid !== sv ||
          if_ready !== (mq.size() < DEPTH)) begin
        n_fail++;
        $display("FAIL rnd_state@%0d: count=%0d/%0d v=%b/%b rdy=%b",
                 c, count, mq.size(), id_valid, sv, if_ready);
      end
      if (sv) begin
        n_tests++;
        if (id_pc !== sd[31:0] || dut_vec() !== ref_dec(sd[63:32])) begin
          n_fail++;
          $display("FAIL rnd_dec@%0d: instr=%h pc=%h/%h got=%h need=%h",
                   c, sd[63:32], id_pc, sd[31:0], dut_vec(),
                   ref_dec(sd[63:32]));
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_store();
    test_backpressure();
    test_csr();
    test_illegal();
    test_flush();
    test_addi();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
